// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: single-cycle integer/branch ops plus a 4-lane signed
// 8-bit multiply-accumulate, with results held in a valid/ready output register.
module alu_exec_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            inValid,
    output logic            inReady,
    input  logic [4:0]      aluOp,
    input  logic [XLEN-1:0] opA,
    input  logic [XLEN-1:0] opB,
    input  logic            accClear,
    output logic            outValid,
    input  logic            outReady,
    output logic [XLEN-1:0] result,
    output logic            branchTaken,
    output logic            zero,
    output logic            illegalOp,
    output logic            busy
);

    localparam logic [4:0] OP_ADD  = 5'b00000;
    localparam logic [4:0] OP_SUB  = 5'b00001;
    localparam logic [4:0] OP_AND  = 5'b00010;
    localparam logic [4:0] OP_OR   = 5'b00011;
    localparam logic [4:0] OP_XOR  = 5'b00100;
    localparam logic [4:0] OP_SLL  = 5'b00101;
    localparam logic [4:0] OP_SRL  = 5'b00110;
    localparam logic [4:0] OP_SRA  = 5'b00111;
    localparam logic [4:0] OP_SLT  = 5'b01000;
    localparam logic [4:0] OP_SLTU = 5'b01001;
    localparam logic [4:0] OP_BEQ  = 5'b01010;
    localparam logic [4:0] OP_BNE  = 5'b01011;
    localparam logic [4:0] OP_BLT  = 5'b01100;
    localparam logic [4:0] OP_BGE  = 5'b01101;
    localparam logic [4:0] OP_BLTU = 5'b01110;
    localparam logic [4:0] OP_BGEU = 5'b01111;
    localparam logic [4:0] OP_VMAC = 5'b10000;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_MAC  = 1'b1
    } state_t;

    state_t          state_r;
    logic [1:0]      lane_r;
    logic [XLEN-1:0] acc_r;
    logic [XLEN-1:0] mac_a_r;
    logic [XLEN-1:0] mac_b_r;
    logic            out_valid_r;
    logic [XLEN-1:0] result_r;
    logic            branch_r;
    logic            zero_r;
    logic            illegal_r;

    logic            in_ready_s;
    logic            accept_s;
    logic            is_vmac_s;
    logic [XLEN-1:0] alu_result_s;
    logic            alu_branch_s;
    logic            alu_illegal_s;
    logic [XLEN-1:0] mac_sum_s;
    logic            load_s;
    logic [XLEN-1:0] load_result_s;
    logic            load_branch_s;
    logic            load_illegal_s;

    // Signed 8x8 product of one lane, sign-extended to the accumulator width
    function automatic logic [XLEN-1:0] lane_product(
        input logic [XLEN-1:0] a,
        input logic [XLEN-1:0] b,
        input logic [1:0]      k
    );
        logic signed [7:0]  la;
        logic signed [7:0]  lb;
        logic signed [15:0] p;
        la = a[{k, 3'b000} +: 8];
        lb = b[{k, 3'b000} +: 8];
        p  = la * lb;
        return {{(XLEN-16){p[15]}}, p};
    endfunction

    assign in_ready_s = (state_r == ST_IDLE) && (!out_valid_r || outReady);
    assign accept_s   = inValid && in_ready_s;
    assign is_vmac_s  = (aluOp == OP_VMAC);
    assign mac_sum_s  = acc_r + lane_product(mac_a_r, mac_b_r, lane_r);

    // Single-cycle integer and branch-compare datapath
    always_comb begin
        alu_result_s  = {XLEN{1'b0}};
        alu_branch_s  = 1'b0;
        alu_illegal_s = 1'b0;
        case (aluOp)
            OP_ADD:  alu_result_s = opA + opB;
            OP_SUB:  alu_result_s = opA - opB;
            OP_AND:  alu_result_s = opA & opB;
            OP_OR:   alu_result_s = opA | opB;
            OP_XOR:  alu_result_s = opA ^ opB;
            OP_SLL:  alu_result_s = opA << opB[4:0];
            OP_SRL:  alu_result_s = opA >> opB[4:0];
            OP_SRA:  alu_result_s = $signed(opA) >>> opB[4:0];
            OP_SLT:  alu_result_s = {{(XLEN-1){1'b0}}, ($signed(opA) < $signed(opB))};
            OP_SLTU: alu_result_s = {{(XLEN-1){1'b0}}, (opA < opB)};
            OP_BEQ:  alu_branch_s = (opA == opB);
            OP_BNE:  alu_branch_s = (opA != opB);
            OP_BLT:  alu_branch_s = ($signed(opA) < $signed(opB));
            OP_BGE:  alu_branch_s = ($signed(opA) >= $signed(opB));
            OP_BLTU: alu_branch_s = (opA < opB);
            OP_BGEU: alu_branch_s = (opA >= opB);
            OP_VMAC: alu_result_s = {XLEN{1'b0}};
            default: alu_illegal_s = 1'b1;
        endcase
    end

    // Select what, if anything, enters the output register this edge
    always_comb begin
        load_s         = 1'b0;
        load_result_s  = {XLEN{1'b0}};
        load_branch_s  = 1'b0;
        load_illegal_s = 1'b0;
        if ((state_r == ST_MAC) && (lane_r == 2'd3)) begin
            load_s        = 1'b1;
            load_result_s = mac_sum_s;
        end else if ((state_r == ST_IDLE) && accept_s && !is_vmac_s) begin
            load_s         = 1'b1;
            load_result_s  = alu_result_s;
            load_branch_s  = alu_branch_s;
            load_illegal_s = alu_illegal_s;
        end else begin
            load_s = 1'b0;
        end
    end

    // Control FSM: accumulator, lane counter and captured VMAC operands
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            lane_r  <= 2'd0;
            acc_r   <= {XLEN{1'b0}};
            mac_a_r <= {XLEN{1'b0}};
            mac_b_r <= {XLEN{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s && is_vmac_s) begin
                        state_r <= ST_MAC;
                        lane_r  <= 2'd0;
                        mac_a_r <= opA;
                        mac_b_r <= opB;
                        if (accClear) begin
                            acc_r <= {XLEN{1'b0}};
                        end
                    end else if (!accept_s && accClear) begin
                        // An idle accClear with no request still clears acc
                        acc_r <= {XLEN{1'b0}};
                    end
                end
                ST_MAC: begin
                    acc_r  <= mac_sum_s;
                    lane_r <= lane_r + 2'd1;
                    if (lane_r == 2'd3) begin
                        state_r <= ST_IDLE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    lane_r  <= 2'd0;
                end
            endcase
        end
    end

    // Output register: a new load wins over a drain on the same edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r <= 1'b0;
            result_r    <= {XLEN{1'b0}};
            branch_r    <= 1'b0;
            zero_r      <= 1'b0;
            illegal_r   <= 1'b0;
        end else if (load_s) begin
            out_valid_r <= 1'b1;
            result_r    <= load_result_s;
            branch_r    <= load_branch_s;
            zero_r      <= (load_result_s == {XLEN{1'b0}});
            illegal_r   <= load_illegal_s;
        end else if (outReady) begin
            out_valid_r <= 1'b0;
        end
    end

    assign inReady     = in_ready_s;
    assign outValid    = out_valid_r;
    assign result      = result_r;
    assign branchTaken = branch_r;
    assign zero        = zero_r;
    assign illegalOp   = illegal_r;
    assign busy        = (state_r != ST_IDLE);

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit: hand-computed vectors, one checking task.
module tb_alu_exec_unit;

    logic        clk;
    logic        rst_n;
    logic        inValid;
    logic        inReady;
    logic [4:0]  aluOp;
    logic [31:0] opA;
    logic [31:0] opB;
    logic        accClear;
    logic        outValid;
    logic        outReady;
    logic [31:0] result;
    logic        branchTaken;
    logic        zero;
    logic        illegalOp;
    logic        busy;

    int errors = 0;
    int checks = 0;

    alu_exec_unit #(.XLEN(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .inValid     (inValid),
        .inReady     (inReady),
        .aluOp       (aluOp),
        .opA         (opA),
        .opB         (opB),
        .accClear    (accClear),
        .outValid    (outValid),
        .outReady    (outReady),
        .result      (result),
        .branchTaken (branchTaken),
        .zero        (zero),
        .illegalOp   (illegalOp),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Present one request for a single edge; caller sits 1 time unit after an edge
    task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic clr);
        inValid  = 1'b1;
        aluOp    = op;
        opA      = a;
        opB      = b;
        accClear = clr;
        check("accept_ready", {31'd0, inReady}, 32'd1);
        @(posedge clk);
        #1;
        inValid  = 1'b0;
        accClear = 1'b0;
    endtask

    task automatic single(input string tag, input logic [4:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_res, input logic exp_br);
        issue(op, a, b, 1'b0);
        check({tag, "_valid"},  {31'd0, outValid},    32'd1);
        check({tag, "_result"}, result,               exp_res);
        check({tag, "_branch"}, {31'd0, branchTaken}, {31'd0, exp_br});
        check({tag, "_zero"},   {31'd0, zero},        {31'd0, (exp_res == 32'd0)});
        check({tag, "_illegal"},{31'd0, illegalOp},   32'd0);
    endtask

    task automatic vmac(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic clr, input logic [31:0] exp_res);
        issue(5'b10000, a, b, clr);
        check({tag, "_busy"},    {31'd0, busy},    32'd1);
        check({tag, "_inready"}, {31'd0, inReady}, 32'd0);
        check({tag, "_early0"},  {31'd0, outValid}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check({tag, "_early"}, {31'd0, outValid}, 32'd0);
        end
        @(posedge clk);
        #1;
        check({tag, "_valid"},  {31'd0, outValid}, 32'd1);
        check({tag, "_result"}, result,            exp_res);
        check({tag, "_idle"},   {31'd0, busy},     32'd0);
        check({tag, "_branch"}, {31'd0, branchTaken}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_n    = 1'b0;
        inValid  = 1'b0;
        aluOp    = 5'd0;
        opA      = 32'd0;
        opB      = 32'd0;
        accClear = 1'b0;
        outReady = 1'b1;
        #12;
        check("rst_valid",   {31'd0, outValid},    32'd0);
        check("rst_result",  result,               32'd0);
        check("rst_branch",  {31'd0, branchTaken}, 32'd0);
        check("rst_zero",    {31'd0, zero},        32'd0);
        check("rst_illegal", {31'd0, illegalOp},   32'd0);
        check("rst_busy",    {31'd0, busy},        32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        check("rst_inready", {31'd0, inReady}, 32'd1);

        single("add",  5'b00000, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0);
        single("sub",  5'b00001, 32'h00001234, 32'h00001234, 32'h00000000, 1'b0);
        single("sra",  5'b00111, 32'h80000000, 32'h00000024, 32'hF8000000, 1'b0);
        single("srl",  5'b00110, 32'h80000000, 32'h00000024, 32'h08000000, 1'b0);
        single("bltu", 5'b01110, 32'h00000001, 32'hFFFFFFFF, 32'h00000000, 1'b1);
        single("blt",  5'b01100, 32'h00000001, 32'hFFFFFFFF, 32'h00000000, 1'b0);
        single("slt",  5'b01000, 32'hFFFFFFFE, 32'h00000003, 32'h00000001, 1'b0);
        single("xor",  5'b00100, 32'hF0F0F0F0, 32'h0FF00FF0, 32'hFF00FF00, 1'b0);
        single("sll",  5'b00101, 32'h00000003, 32'h00000021, 32'h00000006, 1'b0);
        single("bgeu", 5'b01111, 32'h00000005, 32'h00000005, 32'h00000000, 1'b1);

        vmac("vmac1", 32'h01020304, 32'h05FF0207, 1'b1, 32'h00000025);
        vmac("vmac2", 32'h01020304, 32'h05FF0207, 1'b0, 32'h0000004A);

        // Backpressure: hold result, refuse new request, then drain+accept together
        single("bp_add", 5'b00000, 32'd5, 32'd6, 32'd11, 1'b0);
        outReady = 1'b0;
        inValid  = 1'b1;
        aluOp    = 5'b00001;
        opA      = 32'd20;
        opB      = 32'd3;
        #1;
        check("bp_inready_low", {31'd0, inReady}, 32'd0);
        @(posedge clk);
        #1;
        check("bp_hold_valid",  {31'd0, outValid}, 32'd1);
        check("bp_hold_result", result,            32'd11);
        outReady = 1'b1;
        #1;
        check("bp_inready_high", {31'd0, inReady}, 32'd1);
        @(posedge clk);
        #1;
        inValid = 1'b0;
        check("bp_new_valid",  {31'd0, outValid}, 32'd1);
        check("bp_new_result", result,            32'd17);
        @(posedge clk);
        #1;
        check("bp_drained", {31'd0, outValid}, 32'd0);

        // Reset in the middle of a VMAC
        issue(5'b10000, 32'h01020304, 32'h05FF0207, 1'b1);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("mrst_valid",   {31'd0, outValid},    32'd0);
        check("mrst_result",  result,               32'd0);
        check("mrst_branch",  {31'd0, branchTaken}, 32'd0);
        check("mrst_zero",    {31'd0, zero},        32'd0);
        check("mrst_illegal", {31'd0, illegalOp},   32'd0);
        check("mrst_busy",    {31'd0, busy},        32'd0);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("mrst_inready", {31'd0, inReady}, 32'd1);

        // acc must have restarted at zero: four lanes of 1*1 without accClear
        vmac("vmac_after_rst", 32'h01010101, 32'h01010101, 1'b0, 32'h00000004);

        issue(5'b10001, 32'h12345678, 32'h9ABCDEF0, 1'b0);
        check("ill_valid",   {31'd0, outValid},    32'd1);
        check("ill_flag",    {31'd0, illegalOp},   32'd1);
        check("ill_result",  result,               32'd0);
        check("ill_branch",  {31'd0, branchTaken}, 32'd0);

        single("after_ill", 5'b00011, 32'h00000F00, 32'h000000F0, 32'h00000FF0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
